// File: rtl/noc_packetizer_pkg.sv
// Shared widths, flit/header formats and FSM encoding for the injection-side packetizer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package noc_packetizer_pkg;

    localparam int Noc_Data_Width     = 64;
    localparam int Noc_ID_X_Width     = 4;
    localparam int Noc_ID_Y_Width     = 4;
    localparam int Axi_TYPE_Bit       = 4;
    localparam int Axi_LEN_Bit        = 4;
    localparam int Axi_PACK_ORDER_Bit = 4;
    localparam int Less_Byte          = 8;
    localparam int Noc_VC_Channel     = 4;
    localparam int Noc_VC_Sel_Width   = $clog2(Noc_VC_Channel);

    localparam logic [Less_Byte-1:0] Noc_Head_H = 8'hA1;
    localparam logic [Less_Byte-1:0] Noc_Head_E = 8'h1E;
    localparam logic [Less_Byte-1:0] Noc_Tail_H = 8'hB2;
    localparam logic [Less_Byte-1:0] Noc_Tail_E = 8'h2F;

    // Header and tail words share one field layout; only the markers differ.
    localparam int Hdr_Field_Width = 2 * Less_Byte + 2 * Noc_ID_X_Width + 2 * Noc_ID_Y_Width
                                   + Axi_TYPE_Bit + Axi_PACK_ORDER_Bit + Axi_LEN_Bit;
    localparam int Hdr_Pad_Width   = Noc_Data_Width - Hdr_Field_Width;

    typedef struct packed {
        logic                      is_header;
        logic                      is_tail;
        logic [Noc_Data_Width-1:0] data;
    } noc_flit_t;

    typedef enum logic [1:0] {
        PKT_IDLE,
        PKT_HEAD,
        PKT_DATA,
        PKT_TAIL
    } pkt_state_e;

    function automatic logic [Noc_Data_Width-1:0] build_word(
        input logic [Less_Byte-1:0]          mark_h,
        input logic [Less_Byte-1:0]          mark_e,
        input logic [Noc_ID_X_Width-1:0]     src_x,
        input logic [Noc_ID_Y_Width-1:0]     src_y,
        input logic [Noc_ID_X_Width-1:0]     dst_x,
        input logic [Noc_ID_Y_Width-1:0]     dst_y,
        input logic [Axi_TYPE_Bit-1:0]       typ,
        input logic [Axi_PACK_ORDER_Bit-1:0] order,
        input logic [Axi_LEN_Bit-1:0]        len
    );
        return {mark_h, src_x, src_y, dst_x, dst_y, typ, order, len, mark_e,
                {Hdr_Pad_Width{1'b0}}};
    endfunction

    function automatic logic [Noc_Data_Width-1:0] make_header(
        input logic [Noc_ID_X_Width-1:0]     src_x,
        input logic [Noc_ID_Y_Width-1:0]     src_y,
        input logic [Noc_ID_X_Width-1:0]     dst_x,
        input logic [Noc_ID_Y_Width-1:0]     dst_y,
        input logic [Axi_TYPE_Bit-1:0]       typ,
        input logic [Axi_PACK_ORDER_Bit-1:0] order,
        input logic [Axi_LEN_Bit-1:0]        len
    );
        return build_word(Noc_Head_H, Noc_Head_E, src_x, src_y, dst_x, dst_y, typ, order, len);
    endfunction

    function automatic logic [Noc_Data_Width-1:0] make_tail(
        input logic [Noc_ID_X_Width-1:0]     src_x,
        input logic [Noc_ID_Y_Width-1:0]     src_y,
        input logic [Noc_ID_X_Width-1:0]     dst_x,
        input logic [Noc_ID_Y_Width-1:0]     dst_y,
        input logic [Axi_TYPE_Bit-1:0]       typ,
        input logic [Axi_PACK_ORDER_Bit-1:0] order,
        input logic [Axi_LEN_Bit-1:0]        len
    );
        return build_word(Noc_Tail_H, Noc_Tail_E, src_x, src_y, dst_x, dst_y, typ, order, len);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set (callers gate on vc != 0).
    function automatic logic [Noc_VC_Sel_Width-1:0] lowest_vc(input logic [Noc_VC_Channel-1:0] vc);
        logic [Noc_VC_Sel_Width-1:0] idx;
        idx = '0;
        for (int i = Noc_VC_Channel - 1; i >= 0; i--) begin
            if (vc[i]) idx = Noc_VC_Sel_Width'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Request, payload and flit-output bundle between a packet source and the packetizer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on req and pld; per-VC valid/ready on the flit output.
// Modports: slave = packetizer side, master = packet source / router-model side.
interface noc_packetizer_if;
    import noc_packetizer_pkg::*;

    logic                          req_valid;
    logic                          req_ready;
    logic [Noc_ID_X_Width-1:0]     req_dst_x;
    logic [Noc_ID_Y_Width-1:0]     req_dst_y;
    logic [Axi_TYPE_Bit-1:0]       req_type;
    logic [Axi_LEN_Bit-1:0]        req_len;
    logic                          pld_valid;
    logic                          pld_ready;
    logic [Noc_Data_Width-1:0]     pld_data;
    logic [Noc_VC_Channel-1:0]     out_valid;
    logic [Noc_VC_Channel-1:0]     out_ready;
    logic [Noc_VC_Channel-1:0]     vc_ready;
    noc_flit_t                     out_flit;
    logic                          busy;
    logic [15:0]                   pkt_count;

    modport slave (
        input  req_valid, req_dst_x, req_dst_y, req_type, req_len,
        input  pld_valid, pld_data, out_ready, vc_ready,
        output req_ready, pld_ready, out_valid, out_flit, busy, pkt_count
    );

    modport master (
        output req_valid, req_dst_x, req_dst_y, req_type, req_len,
        output pld_valid, pld_data, out_ready, vc_ready,
        input  req_ready, pld_ready, out_valid, out_flit, busy, pkt_count
    );

endinterface

// File: rtl/noc_flit_out_reg.sv
// Single-entry flit output register steering valid onto one VC.
// Latency: 1 cycle from load to out_valid; reloads in the same cycle the held flit is taken.
// Backpressure: holds flit and valid stable until the selected VC's ready is seen.
// Ports: load_i/load_flit_i/load_vc_i in, out_ready_i in, out_valid_o/out_flit_o out,
//        slot_free_o (may load this cycle), xfer_o (held flit transfers this cycle).
module noc_flit_out_reg
    import noc_packetizer_pkg::*;
(
    input  logic                        noc_clk,
    input  logic                        noc_rst_n,
    input  logic                        load_i,
    input  noc_flit_t                   load_flit_i,
    input  logic [Noc_VC_Sel_Width-1:0] load_vc_i,
    input  logic [Noc_VC_Channel-1:0]   out_ready_i,
    output logic [Noc_VC_Channel-1:0]   out_valid_o,
    output noc_flit_t                   out_flit_o,
    output logic                        slot_free_o,
    output logic                        xfer_o
);

    logic [Noc_VC_Channel-1:0] valid_q, valid_d;
    noc_flit_t                 flit_q, flit_d;

    // Only the ready of the VC carrying the held flit matters.
    assign xfer_o      = |(valid_q & out_ready_i);
    assign slot_free_o = (valid_q == '0) | xfer_o;

    always_comb begin
        valid_d = valid_q;
        flit_d  = flit_q;
        if (load_i && slot_free_o) begin
            valid_d            = '0;
            valid_d[load_vc_i] = 1'b1;
            flit_d             = load_flit_i;
        end else if (xfer_o) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            valid_q <= '0;
            flit_q  <= '0;
        end else begin
            valid_q <= valid_d;
            flit_q  <= flit_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_flit_o  = flit_q;

endmodule

// File: rtl/noc_packetizer.sv
// Injection NI: turns a request plus payload beats into header, len+1 data flits and a tail on one VC.
// Latency: request capture 1 cycle, header 1 cycle later, then one flit per cycle while ready.
// Backpressure: stalls in HEAD without a free VC; pld_ready follows output slot availability.
// Ports: noc_clk, noc_rst_n (async active-low), bus (slave modport of noc_packetizer_if).
module noc_packetizer
    import noc_packetizer_pkg::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID = '0
) (
    input  logic            noc_clk,
    input  logic            noc_rst_n,
    noc_packetizer_if.slave bus
);

    pkt_state_e                    state_q;
    logic [Noc_ID_X_Width-1:0]     dst_x_q;
    logic [Noc_ID_Y_Width-1:0]     dst_y_q;
    logic [Axi_TYPE_Bit-1:0]       type_q;
    logic [Axi_LEN_Bit-1:0]        len_q;
    logic [Axi_LEN_Bit-1:0]        cnt_q;
    logic [Axi_PACK_ORDER_Bit-1:0] order_q;
    logic [Noc_VC_Sel_Width-1:0]   vc_sel_q;
    logic                          req_ready_q;
    logic [15:0]                   pkt_count_q;

    logic                          slot_free;
    logic                          xfer;
    logic                          load;
    noc_flit_t                     load_flit;
    logic [Noc_VC_Sel_Width-1:0]   load_vc;
    logic                          tail_xfer;
    logic [Axi_PACK_ORDER_Bit-1:0] order_eff;
    logic                          head_go;
    logic                          pld_fire;
    logic                          tail_go;

    assign tail_xfer = xfer & bus.out_flit.is_tail;
    // A header can load in the same cycle the previous tail drains; it must carry the
    // already-advanced order, not the value still sitting in order_q.
    assign order_eff = order_q + Axi_PACK_ORDER_Bit'(tail_xfer);

    assign head_go  = (state_q == PKT_HEAD) && slot_free && (bus.vc_ready != '0);
    assign pld_fire = (state_q == PKT_DATA) && slot_free && bus.pld_valid;
    assign tail_go  = (state_q == PKT_TAIL) && slot_free;

    always_comb begin
        load      = 1'b0;
        load_flit = '0;
        load_vc   = vc_sel_q;
        if (head_go) begin
            load                = 1'b1;
            load_vc             = lowest_vc(bus.vc_ready);
            load_flit.is_header = 1'b1;
            load_flit.data      = make_header(X_ID, Y_ID, dst_x_q, dst_y_q, type_q, order_eff, len_q);
        end else if (pld_fire) begin
            load           = 1'b1;
            load_flit.data = bus.pld_data;
        end else if (tail_go) begin
            load              = 1'b1;
            load_flit.is_tail = 1'b1;
            load_flit.data    = make_tail(X_ID, Y_ID, dst_x_q, dst_y_q, type_q, order_eff, len_q);
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= PKT_IDLE;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            type_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            order_q     <= '0;
            vc_sel_q    <= '0;
            req_ready_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            if (tail_xfer) begin
                order_q     <= order_q + 1'b1;
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            case (state_q)
                PKT_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        dst_x_q     <= bus.req_dst_x;
                        dst_y_q     <= bus.req_dst_y;
                        type_q      <= bus.req_type;
                        len_q       <= bus.req_len;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= PKT_HEAD;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                PKT_HEAD: begin
                    if (head_go) begin
                        vc_sel_q <= lowest_vc(bus.vc_ready);
                        state_q  <= PKT_DATA;
                    end
                end
                PKT_DATA: begin
                    // Compare before increment: len all-ones still ends cleanly.
                    if (pld_fire) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == len_q) state_q <= PKT_TAIL;
                    end
                end
                PKT_TAIL: begin
                    if (tail_go) begin
                        req_ready_q <= 1'b1;
                        state_q     <= PKT_IDLE;
                    end
                end
                default: state_q <= PKT_IDLE;
            endcase
        end
    end

    noc_flit_out_reg u_out_reg (
        .noc_clk     (noc_clk),
        .noc_rst_n   (noc_rst_n),
        .load_i      (load),
        .load_flit_i (load_flit),
        .load_vc_i   (load_vc),
        .out_ready_i (bus.out_ready),
        .out_valid_o (bus.out_valid),
        .out_flit_o  (bus.out_flit),
        .slot_free_o (slot_free),
        .xfer_o      (xfer)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.pld_ready = (state_q == PKT_DATA) && slot_free;
    assign bus.busy      = (state_q != PKT_IDLE) || (bus.out_valid != '0);
    assign bus.pkt_count = pkt_count_q;

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Injection-side network interface for one mesh node. Sits directly upstream of the router's local input port.
- Accepts a packet request (destination, type, length) and a payload beat stream.
- Emits a wormhole packet on the local flit interface: one header flit, len+1 data flits, one tail flit.
- Selects one virtual channel per packet and holds it until the tail flit is accepted.

Parameters:
- X_ID, 0, this node's X coordinate (Noc_ID_X_Width bits).
- Y_ID, 0, this node's Y coordinate (Noc_ID_Y_Width bits).

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  packet request valid
- req_ready  out  1  packet request accepted
- req_dst_x  in  Noc_ID_X_Width  destination X
- req_dst_y  in  Noc_ID_Y_Width  destination Y
- req_type  in  Axi_TYPE_Bit  packet type field
- req_len  in  Axi_LEN_Bit  data flit count minus 1
- pld_valid  in  1  payload beat valid
- pld_ready  out  1  payload beat accepted
- pld_data  in  Noc_Data_Width  payload beat
- out_valid  out  Noc_VC_Channel  per-VC flit valid (at most one bit set)
- out_ready  in  Noc_VC_Channel  per-VC router ready
- vc_ready  in  Noc_VC_Channel  VC free for a new packet
- out_flit  out  Noc_Data_Width+2  {is_header, is_tail, data}
- busy  out  1  packet in progress or flit pending
- pkt_count  out  16  packets completed (tail accepted), wraps

Behaviour:
- Reset: FSM=IDLE; out_valid=0; out_flit=0; req_ready=0 during reset, 1 after; pld_ready=0; busy=0; pkt_count=0; pack_order=0; vc_sel=0.
- Reset mid-packet: partial packet is dropped. No tail is emitted.
- Output register: "slot free" = out_valid==0, or (out_valid & out_ready)!=0 this cycle. A flit loads only when the slot is free. out_valid and out_flit are held stable until accepted.
- Transfer: occurs on the cycle where out_valid[v] & out_ready[v].
- FSM states: IDLE, HEAD, DATA, TAIL.
- IDLE:
  - req_ready=1.
  - On req_valid, capture dst/type/len into registers, set beat counter=0, go to HEAD.
  - A request may be captured while the previous tail is still pending in the output register.
- HEAD:
  - Requires slot free and vc_ready!=0.
  - vc_sel = lowest-index set bit of vc_ready.
  - Load header = {Noc_Head_H, X_ID, Y_ID, dst_x, dst_y, type, pack_order, len, Noc_Head_E, zero pad}, with is_header=1 and is_tail=0.
  - Drive out_valid=onehot(vc_sel). Go to DATA.
  - If vc_ready==0, wait in HEAD.
- DATA:
  - pld_ready = slot free.
  - On pld_valid & pld_ready: load {0,0,pld_data} on vc_sel and increment the counter.
  - When counter==len at the accepting beat, go to TAIL.
  - Minimum latency is one cycle per beat. Zero-bubble streaming occurs when out_ready stays high.
- TAIL:
  - On slot free: load tail = {Noc_Tail_H, X_ID, Y_ID, dst, type, pack_order, len, Noc_Tail_E, pad}, with is_header=0 and is_tail=1.
  - Go to IDLE.
- Tail acceptance: pack_order increments, modulo 2^Axi_PACK_ORDER_Bit. pkt_count increments, wrapping from 0xFFFF to 0.
- vc_sel is never changed between header and tail, regardless of vc_ready.
- out_ready on a VC other than vc_sel is ignored.
- req_len max (all ones): yields 2^Axi_LEN_Bit data flits. The counter is Axi_LEN_Bit wide and compares before increment, so there is no overflow.
- busy = (FSM!=IDLE) | (out_valid!=0).

Decomposition:
- Noc_parameters package (existing) supplies:
  - widths: Noc_Data_Width, Noc_ID_X/Y_Width, Axi_*_Bit, Less_Byte, Noc_VC_Channel
  - Noc_Head_H/E and Noc_Tail_H/E markers
- Add to the package:
  - typedef noc_flit_t for {is_header, is_tail, data}
  - functions make_header()/make_tail() building the header/tail words from fields
  - enum pkt_state_e for the FSM
- One sub-module is natural: noc_flit_out_reg, the single-entry valid/ready output register with per-VC valid steering.

Test Plan:
- Reset, then req dst=(2,1) len=0, pld=0xA5, out_ready=all 1, vc_ready=1 -> exactly 3 flits on VC0: header (is_header=1, dst fields 2,1, pack_order 0), data 0xA5, tail (is_tail=1). pkt_count=1.
- len=3, out_ready[0] toggling 1/0 each cycle -> 4 data flits in order, each held stable while ready=0, no duplicates or drops. Tail follows the 4th data flit.
- vc_ready=4'b0110 at header -> out_valid=4'b0010 for all flits. vc_ready dropping to 0 mid-packet does not stall or retarget.
- Two back-to-back requests with req_valid held high -> second header on the cycle after the first tail is accepted. pack_order 0 then 1. req_ready=1 the cycle after the first tail loads.
- pld_valid gaps of 2 cycles between beats -> out_valid low during gaps. Data order preserved. pld_ready asserted only in DATA with a free slot.
- Assert noc_rst_n=0 during the 2nd data flit of len=3 -> out_valid=0 immediately (asynchronous). After release: IDLE, req_ready=1, pkt_count unchanged (0). A new packet sends correctly.
